// File: rtl/adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM encoding and the
// step-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; each bit is a full adder made of two
// half-adder cells and an OR gate.
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic hs_s;
    logic hc0_s;
    logic hc1_s;

    half_adder u_ha0 (.a(a[i]), .b(b[i]),   .s(hs_s), .c(hc0_s));
    half_adder u_ha1 (.a(hs_s), .b(c_s[i]), .s(s[i]), .c(hc1_s));

    assign c_s[i+1] = hc0_s | hc1_s;
  end

  assign cout = c_s[CHUNK];

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell from the arithmetic library.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder with carry-in that processes CHUNK bits per
// cycle, with a start/busy/done handshake.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_chunk_adder: CHUNK must be >= 1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    step_q, step_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout_s;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sh_q[CHUNK-1:0]),
    .b    (b_sh_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout_s)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    step_d      = step_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          step_d  = '0;
          sum_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Result chunks enter at the MSB end so the first one ends at bit 0.
        sum_d   = WIDTH'({chunk_s, sum_q} >> CHUNK);
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        carry_d = chunk_cout_s;
        step_d  = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          state_d     = ST_DONE;
          carry_out_d = chunk_cout_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      step_q      <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      step_q      <= step_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_out_q;

endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Parametrised multi-cycle adder that generalises the single-bit half adder into a WIDTH-bit add with carry-in. Each cycle it processes CHUNK bits through a small combinational chunk adder and carries between cycles in a register. It uses a start/busy/done handshake and sits in the arithmetic library as the area-cheap alternative to a flat ripple adder.

## Interface

Parameters:
- WIDTH, 8: operand and sum width in bits; must be ≥ 1.
- CHUNK, 1: bits added per cycle; must divide WIDTH exactly. STEPS = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new add. Sampled only in IDLE or DONE.
- A  input  WIDTH  operand A. Captured on the accepting edge.
- B  input  WIDTH  operand B. Captured on the accepting edge.
- Cin  input  1  carry-in. Captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when Sum and Carry become valid.
- Sum  output  WIDTH  result; holds until the next accepted start.
- Carry  output  1  carry-out; holds with Sum.

## Operation

- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→RUN while step < STEPS-1.
  - RUN→DONE on the last step.
  - DONE→RUN on start; DONE→IDLE otherwise.
- Accepting edge:
  - Load the A and B shift registers.
  - Load the carry register with Cin.
  - Clear the step counter and the Sum register.
- Each RUN edge:
  - chunk_adder adds the CHUNK LSBs of A_sh and B_sh plus the carry register.
  - The CHUNK result bits shift into Sum from the MSB end, so after STEPS shifts the LSB chunk sits at Sum[CHUNK-1:0].
  - A_sh and B_sh shift right by CHUNK.
  - The carry register takes the chunk carry-out.
  - The step counter increments.
- On the edge entering DONE, Carry takes the final chunk carry-out.
- Arithmetic: {Carry, Sum} = A + B + Cin, modulo 2^(WIDTH+1), always exact with no overflow flag.
- start while in RUN is ignored. Operands are not re-sampled and the in-flight add is unaffected.
- A, B and Cin may change freely after the accepting edge.
- Reset values: state IDLE, busy 0, done 0, Sum 0, Carry 0, step counter 0, internal carry 0.
- rst asserted mid-RUN aborts the add. Outputs take their reset values on that edge and no done is issued.
- rst has priority over start on the same edge.

## Timing

- Let start be accepted on edge k.
- busy is high for cycles k+1 … k+STEPS, exactly STEPS cycles.
- done is high only in cycle k+STEPS+1, when Sum and Carry are valid.
- Latency from accepting edge to done is STEPS+1 cycles.
- Back-to-back: start high during the done cycle is accepted on that edge. busy is high in the next cycle and done drops. Throughput is one result per STEPS+1 cycles.
- Sum and Carry are stable from the done cycle until the next accepting edge.
- Sum may show partial values while busy; consumers sample only on done.
- CHUNK = WIDTH gives STEPS = 1: one RUN cycle, done two cycles after start.

## Structure

- Shared package adder_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the step-counter width function clog2(STEPS), minimum 1 bit.
- Sub-module chunk_adder (parameter CHUNK):
  - purely combinational, a CHUNK-bit full-adder ripple;
  - ports a, b, cin, s, cout;
  - built from the existing half-adder cells (two half adders plus OR per bit).
- Top level holds the FSM, step counter, shift registers and output registers.
- Elaboration-time check: WIDTH % CHUNK == 0; error otherwise.

## Test plan

- WIDTH=8, CHUNK=1: A=8'hFF, B=8'h01, Cin=0. busy is high 8 cycles, then done for one cycle with Sum=8'h00 and Carry=1.
- WIDTH=8, CHUNK=1: A=8'hA5, B=8'h5A, Cin=1 → Sum=8'h00, Carry=1. Then A=8'h12, B=8'h34, Cin=0 issued in the done cycle → busy the next cycle, Sum=8'h46, Carry=0 nine cycles later.
- WIDTH=8, CHUNK=4: A=8'h3C, B=8'h0F, Cin=0 → busy 2 cycles, done at start+3 with Sum=8'h4B, Carry=0.
- start pulsed at RUN step 3 with A=8'h00, B=8'h00 during the add of 8'h80+8'h80: the pulse is ignored and the result is Sum=8'h00, Carry=1.
- rst asserted at RUN step 4: the next cycle shows busy=0, done=0, Sum=0, Carry=0, and no done pulse follows.
- Random sweep with WIDTH=16, CHUNK=2, 1000 operand sets: {Carry,Sum} matches the A+B+Cin model on every done, and done width is always one cycle.
